// File: rtl/bus_pkg.sv
// Shared bus-fabric definitions: DMA FSM state encoding, data width and
// memory-map base addresses used by the interconnect, masters and benches.
package bus_pkg;

    localparam int unsigned BUS_DATA_WIDTH = 32;

    localparam logic [31:0] ROM_BASE  = 32'h0000_0000;
    localparam logic [31:0] RAM_BASE  = 32'h2000_0000;
    localparam logic [31:0] MMIO_BASE = 32'h4000_0000;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WRITE   = 3'd3,
        DONE    = 3'd4
    } dma_state_t;

endpackage

// File: rtl/dma_engine_if.sv
// Valid/ready read and write channels between a bus master and the fabric.
interface dma_engine_if;
    import bus_pkg::*;

    logic [31:0]               dmaAxiReadAddress;
    logic                      dmaAxiReadValid;
    logic                      dmaAxiReadReady;
    logic [BUS_DATA_WIDTH-1:0] dmaAxiReadData;
    logic                      dmaAxiReadValidData;
    logic                      dmaAxiReadReadyData;
    logic [31:0]               dmaAxiWriteAddress;
    logic                      dmaAxiWriteValid;
    logic                      dmaAxiWriteReady;
    logic [BUS_DATA_WIDTH-1:0] dmaAxiWriteData;
    logic                      dmaAxiWriteValidData;
    logic                      dmaAxiWriteReadyData;

    modport master (
        output dmaAxiReadAddress, dmaAxiReadValid, dmaAxiReadReadyData,
        input  dmaAxiReadReady, dmaAxiReadData, dmaAxiReadValidData,
        output dmaAxiWriteAddress, dmaAxiWriteValid, dmaAxiWriteData, dmaAxiWriteValidData,
        input  dmaAxiWriteReady, dmaAxiWriteReadyData
    );

    modport slave (
        input  dmaAxiReadAddress, dmaAxiReadValid, dmaAxiReadReadyData,
        output dmaAxiReadReady, dmaAxiReadData, dmaAxiReadValidData,
        input  dmaAxiWriteAddress, dmaAxiWriteValid, dmaAxiWriteData, dmaAxiWriteValidData,
        output dmaAxiWriteReady, dmaAxiWriteReadyData
    );

endinterface

// File: rtl/dma_engine.sv
// Single-channel word-granular memory-to-memory copy engine: one read beat
// then one write beat per word over the fabric's valid/ready channels.
module dma_engine
    import bus_pkg::*;
#(
    parameter int unsigned COUNT_WIDTH    = 16,
    parameter int unsigned ADDRESS_STRIDE = 4
) (
    input  logic                   clock,
    input  logic                   resetActiveLow,
    input  logic [31:0]            cfgSourceAddress,
    input  logic [31:0]            cfgDestAddress,
    input  logic [COUNT_WIDTH-1:0] cfgWordCount,
    input  logic                   cfgSourceIncrement,
    input  logic                   cfgDestIncrement,
    input  logic                   cfgStart,
    output logic                   statusBusy,
    output logic                   statusDone,
    dma_engine_if.master           bus
);

    localparam logic [31:0] STRIDE = 32'(ADDRESS_STRIDE);

    dma_state_t                state_q, state_d;
    logic [31:0]               src_q, src_d;
    logic [31:0]               dst_q, dst_d;
    logic [COUNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic                      src_inc_q, src_inc_d;
    logic                      dst_inc_q, dst_inc_d;
    logic [BUS_DATA_WIDTH-1:0] data_q, data_d;
    logic                      aw_done_q, aw_done_d;
    logic                      w_done_q, w_done_d;
    logic                      done_q, done_d;

    always_ff @(posedge clock or negedge resetActiveLow) begin
        if (!resetActiveLow) begin
            state_q   <= IDLE;
            src_q     <= '0;
            dst_q     <= '0;
            cnt_q     <= '0;
            src_inc_q <= 1'b0;
            dst_inc_q <= 1'b0;
            data_q    <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            cnt_q     <= cnt_d;
            src_inc_q <= src_inc_d;
            dst_inc_q <= dst_inc_d;
            data_q    <= data_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        dst_d     = dst_q;
        cnt_d     = cnt_q;
        src_inc_d = src_inc_q;
        dst_inc_d = dst_inc_q;
        data_d    = data_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        done_d    = done_q;

        unique case (state_q)
            IDLE: begin
                if (cfgStart) begin
                    src_d     = cfgSourceAddress;
                    dst_d     = cfgDestAddress;
                    cnt_d     = cfgWordCount;
                    src_inc_d = cfgSourceIncrement;
                    dst_inc_d = cfgDestIncrement;
                    done_d    = 1'b0;
                    state_d   = (cfgWordCount == '0) ? DONE : RD_ADDR;
                end
            end
            RD_ADDR: begin
                if (bus.dmaAxiReadReady) state_d = RD_DATA;
            end
            RD_DATA: begin
                if (bus.dmaAxiReadValidData) begin
                    data_d  = bus.dmaAxiReadData;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                // Address and data handshakes may land in any order; the word
                // retires on the cycle the later of the two completes.
                aw_done_d = aw_done_q | bus.dmaAxiWriteReady;
                w_done_d  = w_done_q  | bus.dmaAxiWriteReadyData;
                if (aw_done_d && w_done_d) begin
                    cnt_d     = cnt_q - COUNT_WIDTH'(1);
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    if (src_inc_q) src_d = src_q + STRIDE;
                    if (dst_inc_q) dst_d = dst_q + STRIDE;
                    state_d   = (cnt_q == COUNT_WIDTH'(1)) ? DONE : RD_ADDR;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.dmaAxiReadAddress    = src_q;
        bus.dmaAxiReadValid      = (state_q == RD_ADDR) || (state_q == RD_DATA);
        bus.dmaAxiReadReadyData  = (state_q == RD_DATA);
        bus.dmaAxiWriteAddress   = dst_q;
        bus.dmaAxiWriteData      = data_q;
        // Address valid stays up until both beats finish so the fabric keeps
        // the write data path routed to this master.
        bus.dmaAxiWriteValid     = (state_q == WRITE);
        bus.dmaAxiWriteValidData = (state_q == WRITE) && !w_done_q;
        statusBusy               = (state_q == RD_ADDR) || (state_q == RD_DATA) ||
                                   (state_q == WRITE);
        statusDone               = done_q;
    end

endmodule

// File: tb/tb_dma_engine.sv
// Scoreboard bench for dma_engine: expected read/write beats are queued at
// start, a behavioural slave answers with programmable latencies.
module tb_dma_engine;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clock = 1'b0;
    logic        resetActiveLow = 1'b0;
    logic [31:0] cfgSourceAddress = '0;
    logic [31:0] cfgDestAddress = '0;
    logic [15:0] cfgWordCount = '0;
    logic        cfgSourceIncrement = 1'b0;
    logic        cfgDestIncrement = 1'b0;
    logic        cfgStart = 1'b0;
    logic        statusBusy;
    logic        statusDone;

    dma_engine_if bus_if ();

    dma_engine #(.COUNT_WIDTH(16), .ADDRESS_STRIDE(4)) dut (
        .clock              (clock),
        .resetActiveLow     (resetActiveLow),
        .cfgSourceAddress   (cfgSourceAddress),
        .cfgDestAddress     (cfgDestAddress),
        .cfgWordCount       (cfgWordCount),
        .cfgSourceIncrement (cfgSourceIncrement),
        .cfgDestIncrement   (cfgDestIncrement),
        .cfgStart           (cfgStart),
        .statusBusy         (statusBusy),
        .statusDone         (statusDone),
        .bus                (bus_if)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    logic [31:0] rd_q[$];
    wr_t         wr_q[$];
    logic [31:0] cur_rd = '0;
    int          busy_cycles = 0;
    int          valid_cycles = 0;
    int          writes_done = 0;

    int rd_addr_lat = 0, rd_data_lat = 0, wa_lat = 0, wd_lat = 0;
    bit junk_early = 1'b0;

    task automatic check(input bit ok, input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Source memory contents as a function of the byte address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]};
    endfunction

    // Behavioural slave, driven on the falling edge.
    int rcnt = 0, dcnt = 0, awcnt = 0, wcnt = 0;
    always @(negedge clock) begin
        if (!resetActiveLow) begin
            bus_if.dmaAxiReadReady      = 1'b0;
            bus_if.dmaAxiReadValidData  = 1'b0;
            bus_if.dmaAxiReadData       = '0;
            bus_if.dmaAxiWriteReady     = 1'b0;
            bus_if.dmaAxiWriteReadyData = 1'b0;
            rcnt = 0; dcnt = 0; awcnt = 0; wcnt = 0;
        end else begin
            bus_if.dmaAxiReadReady     = 1'b0;
            bus_if.dmaAxiReadValidData = 1'b0;
            bus_if.dmaAxiReadData      = '0;
            if (bus_if.dmaAxiReadValid && !bus_if.dmaAxiReadReadyData) begin
                bus_if.dmaAxiReadReady = (rcnt >= rd_addr_lat);
                if (junk_early && bus_if.dmaAxiReadReady) begin
                    bus_if.dmaAxiReadValidData = 1'b1;
                    bus_if.dmaAxiReadData      = 32'hDEAD_BEEF;
                end
                rcnt++;
                dcnt = 0;
            end else if (bus_if.dmaAxiReadValid) begin
                bus_if.dmaAxiReadValidData = (dcnt >= rd_data_lat);
                bus_if.dmaAxiReadData      = mem_word(bus_if.dmaAxiReadAddress);
                dcnt++;
                rcnt = 0;
            end else begin
                rcnt = 0; dcnt = 0;
            end
            if (bus_if.dmaAxiWriteValid) begin
                bus_if.dmaAxiWriteReady     = (awcnt >= wa_lat);
                bus_if.dmaAxiWriteReadyData = (wcnt >= wd_lat);
                awcnt++; wcnt++;
            end else begin
                bus_if.dmaAxiWriteReady     = 1'b0;
                bus_if.dmaAxiWriteReadyData = 1'b0;
                awcnt = 0; wcnt = 0;
            end
        end
    end

    // Monitor: evaluates the handshakes that the next rising edge will take.
    bit          aw_seen = 1'b0, w_seen = 1'b0;
    logic [31:0] w_data = '0;
    wr_t         exp_w;
    always @(negedge clock) begin
        #1;
        if (!resetActiveLow) begin
            aw_seen = 1'b0;
            w_seen  = 1'b0;
        end else begin
            if (statusBusy) busy_cycles++;
            if (bus_if.dmaAxiReadValid || bus_if.dmaAxiWriteValid) valid_cycles++;
            if (bus_if.dmaAxiReadValid && !bus_if.dmaAxiReadReadyData) begin
                check(rd_q.size() != 0, "rd_unexpected", bus_if.dmaAxiReadAddress, '0);
                if (rd_q.size() != 0) begin
                    check(bus_if.dmaAxiReadAddress == rd_q[0], "rd_addr",
                          bus_if.dmaAxiReadAddress, rd_q[0]);
                    if (bus_if.dmaAxiReadReady) cur_rd = rd_q.pop_front();
                end
            end else if (bus_if.dmaAxiReadValid) begin
                check(bus_if.dmaAxiReadAddress == cur_rd, "rd_addr_hold",
                      bus_if.dmaAxiReadAddress, cur_rd);
            end
            if (aw_seen != w_seen)
                check(bus_if.dmaAxiWriteValid, "wr_valid_hold",
                      {31'd0, bus_if.dmaAxiWriteValid}, 32'd1);
            if (bus_if.dmaAxiWriteValid) begin
                check(wr_q.size() != 0, "wr_unexpected", bus_if.dmaAxiWriteAddress, '0);
                if (wr_q.size() != 0) begin
                    check(bus_if.dmaAxiWriteAddress == wr_q[0].addr, "wr_addr",
                          bus_if.dmaAxiWriteAddress, wr_q[0].addr);
                    if (bus_if.dmaAxiWriteReady) aw_seen = 1'b1;
                    if (bus_if.dmaAxiWriteValidData && bus_if.dmaAxiWriteReadyData) begin
                        check(!w_seen, "wr_data_dup", bus_if.dmaAxiWriteData, '0);
                        w_seen = 1'b1;
                        w_data = bus_if.dmaAxiWriteData;
                    end
                    if (aw_seen && w_seen) begin
                        exp_w = wr_q.pop_front();
                        check(w_data == exp_w.data, "wr_data", w_data, exp_w.data);
                        writes_done++;
                        aw_seen = 1'b0;
                        w_seen  = 1'b0;
                    end
                end
            end
        end
    end

    task automatic expect_copy(input logic [31:0] src, input logic [31:0] dst,
                               input int n, input bit si, input bit di);
        logic [31:0] s = src, d = dst;
        for (int i = 0; i < n; i++) begin
            rd_q.push_back(s);
            wr_q.push_back('{addr: d, data: mem_word(s)});
            if (si) s = s + 32'd4;
            if (di) d = d + 32'd4;
        end
    endtask

    task automatic start(input logic [31:0] src, input logic [31:0] dst,
                         input logic [15:0] n, input bit si, input bit di);
        @(negedge clock);
        cfgSourceAddress   = src;
        cfgDestAddress     = dst;
        cfgWordCount       = n;
        cfgSourceIncrement = si;
        cfgDestIncrement   = di;
        cfgStart           = 1'b1;
        busy_cycles  = 0;
        valid_cycles = 0;
        writes_done  = 0;
        @(negedge clock);
        cfgStart = 1'b0;
    endtask

    task automatic wait_done(input string name, input int limit);
        int n = 0;
        while (!statusDone && n < limit) begin
            @(negedge clock);
            n++;
        end
        check(statusDone, name, {31'd0, statusDone}, 32'd1);
        repeat (2) @(negedge clock);
    endtask

    task automatic check_drained(input string name);
        check(rd_q.size() == 0, {name, "_rd_left"}, rd_q.size(), 0);
        check(wr_q.size() == 0, {name, "_wr_left"}, wr_q.size(), 0);
    endtask

    initial begin
        int n;
        #2;
        check(!statusBusy && !statusDone && !bus_if.dmaAxiReadValid &&
              !bus_if.dmaAxiWriteValid && !bus_if.dmaAxiWriteValidData &&
              !bus_if.dmaAxiReadReadyData, "reset_flags",
              {26'd0, statusBusy, statusDone, bus_if.dmaAxiReadValid,
               bus_if.dmaAxiWriteValid, bus_if.dmaAxiWriteValidData,
               bus_if.dmaAxiReadReadyData}, '0);
        check(bus_if.dmaAxiReadAddress == '0, "reset_raddr", bus_if.dmaAxiReadAddress, '0);
        repeat (2) @(negedge clock);
        resetActiveLow = 1'b1;

        // Basic copy, zero-wait slave: 3 cycles/word, done one cycle after DONE.
        expect_copy(32'h2000_0000, 32'h2000_0100, 4, 1'b1, 1'b1);
        start(32'h2000_0000, 32'h2000_0100, 16'd4, 1'b1, 1'b1);
        check(statusBusy, "basic_busy_start", {31'd0, statusBusy}, 32'd1);
        repeat (12) @(negedge clock);
        check(!statusDone, "basic_done_early", {31'd0, statusDone}, 32'd0);
        @(negedge clock);
        #2;
        check(statusDone, "basic_done", {31'd0, statusDone}, 32'd1);
        check(busy_cycles == 12, "basic_busy_cycles", busy_cycles, 12);
        check(writes_done == 4, "basic_writes", writes_done, 4);
        check_drained("basic");

        // Zero count: no traffic, done two cycles after start, sticky.
        start(32'h2000_0000, 32'h2000_0100, 16'd0, 1'b1, 1'b1);
        check(!statusDone, "zero_done_cleared", {31'd0, statusDone}, 32'd0);
        check(!statusBusy, "zero_busy", {31'd0, statusBusy}, 32'd0);
        @(negedge clock);
        check(statusDone, "zero_done", {31'd0, statusDone}, 32'd1);
        repeat (3) @(negedge clock);
        check(statusDone, "zero_done_sticky", {31'd0, statusDone}, 32'd1);
        check(valid_cycles == 0, "zero_valid_cycles", valid_cycles, 0);
        check(busy_cycles == 0, "zero_busy_cycles", busy_cycles, 0);

        // Fixed destination.
        rd_q.push_back(32'h2000_0000); wr_q.push_back('{32'h4000_0000, mem_word(32'h2000_0000)});
        rd_q.push_back(32'h2000_0004); wr_q.push_back('{32'h4000_0000, mem_word(32'h2000_0004)});
        rd_q.push_back(32'h2000_0008); wr_q.push_back('{32'h4000_0000, mem_word(32'h2000_0008)});
        start(32'h2000_0000, 32'h4000_0000, 16'd3, 1'b1, 1'b0);
        wait_done("fixed_done", 100);
        check(writes_done == 3, "fixed_writes", writes_done, 3);
        check_drained("fixed");

        // Write handshake orderings: addr first, data first, simultaneous.
        for (int k = 0; k < 3; k++) begin
            wa_lat = (k == 1) ? 3 : (k == 2 ? 2 : 0);
            wd_lat = (k == 0) ? 3 : (k == 2 ? 2 : 0);
            expect_copy(32'h2000_0040, 32'h2000_0800, 2, 1'b1, 1'b1);
            start(32'h2000_0040, 32'h2000_0800, 16'd2, 1'b1, 1'b1);
            wait_done("order_done", 100);
            check(writes_done == 2, "order_writes", writes_done, 2);
            check_drained("order");
        end
        wa_lat = 0; wd_lat = 0;

        // Read stalls, with bogus data offered during the address phase.
        rd_addr_lat = 5; rd_data_lat = 7; junk_early = 1'b1;
        expect_copy(32'h2000_1000, 32'h2000_2000, 2, 1'b1, 1'b1);
        start(32'h2000_1000, 32'h2000_2000, 16'd2, 1'b1, 1'b1);
        wait_done("stall_done", 200);
        check(busy_cycles == 2 * (6 + 8 + 1), "stall_busy_cycles", busy_cycles, 30);
        check_drained("stall");
        rd_addr_lat = 0; rd_data_lat = 0; junk_early = 1'b0;

        // Reset during the write of word 2.
        wd_lat = 3;
        expect_copy(32'h2000_0000, 32'h2000_0300, 4, 1'b1, 1'b1);
        start(32'h2000_0000, 32'h2000_0300, 16'd4, 1'b1, 1'b1);
        n = 0;
        #2;
        while (!(writes_done == 1 && bus_if.dmaAxiWriteValid) && n < 50) begin
            @(negedge clock);
            #2;
            n++;
        end
        check(n < 50, "reset_reach_word2", n, 50);
        #1 resetActiveLow = 1'b0;
        #1;
        check(!statusBusy && !statusDone && !bus_if.dmaAxiReadValid &&
              !bus_if.dmaAxiWriteValid && !bus_if.dmaAxiWriteValidData &&
              !bus_if.dmaAxiReadReadyData, "midreset_flags",
              {26'd0, statusBusy, statusDone, bus_if.dmaAxiReadValid,
               bus_if.dmaAxiWriteValid, bus_if.dmaAxiWriteValidData,
               bus_if.dmaAxiReadReadyData}, '0);
        check(bus_if.dmaAxiWriteAddress == '0, "midreset_waddr", bus_if.dmaAxiWriteAddress, '0);
        check(bus_if.dmaAxiWriteData == '0, "midreset_wdata", bus_if.dmaAxiWriteData, '0);
        check(bus_if.dmaAxiReadAddress == '0, "midreset_raddr", bus_if.dmaAxiReadAddress, '0);
        repeat (2) @(negedge clock);
        rd_q.delete();
        wr_q.delete();
        wd_lat = 0;
        #3 resetActiveLow = 1'b1;
        repeat (2) @(negedge clock);
        check(!statusDone, "postreset_done", {31'd0, statusDone}, 32'd0);

        // Source address wraps past 2^32.
        rd_q.push_back(32'hFFFF_FFFC); wr_q.push_back('{32'h2000_0400, mem_word(32'hFFFF_FFFC)});
        rd_q.push_back(32'h0000_0000); wr_q.push_back('{32'h2000_0404, mem_word(32'h0000_0000)});
        start(32'hFFFF_FFFC, 32'h2000_0400, 16'd2, 1'b1, 1'b1);
        wait_done("wrap_done", 100);
        check(writes_done == 2, "wrap_writes", writes_done, 2);
        check_drained("wrap");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule

// File: doc/dma_engine.md
Name: dma_engine

Overview:
Bus Master 1 of the bus interconnect: a single-channel, word-granular memory-to-memory copy engine. It copies cfgWordCount 32-bit words from a source address to a destination address, one read beat followed by one write beat per word, over the fabric's valid/ready read and write channels. Its configuration inputs are driven by an MMIO register block, and its done flag feeds that register block.

Parameters:
COUNT_WIDTH, 16, width of the word-count field and the internal remaining-words counter.
ADDRESS_STRIDE, 4, byte increment applied to an incrementing address after each word.

Ports:
clock  input  1  system clock; all state updates on its rising edge.
resetActiveLow  input  1  asynchronous, active-low reset.
cfgSourceAddress  input  32  first source byte address; sampled on start.
cfgDestAddress  input  32  first destination byte address; sampled on start.
cfgWordCount  input  COUNT_WIDTH  number of words to copy; sampled on start.
cfgSourceIncrement  input  1  1 = source address advances by stride; 0 = fixed (FIFO/MMIO source).
cfgDestIncrement  input  1  1 = destination address advances by stride; 0 = fixed.
cfgStart  input  1  single-cycle start pulse.
statusBusy  output  1  high from the cycle after an accepted start until the transfer completes.
statusDone  output  1  sticky completion flag; cleared by the next accepted start.
dmaAxiReadAddress  output  32  read address.
dmaAxiReadValid  output  1  read request valid.
dmaAxiReadReady  input  1  read address accepted.
dmaAxiReadData  input  32  read data.
dmaAxiReadValidData  input  1  read data valid.
dmaAxiReadReadyData  output  1  engine ready for read data.
dmaAxiWriteAddress  output  32  write address.
dmaAxiWriteValid  output  1  write request valid.
dmaAxiWriteReady  input  1  write address accepted.
dmaAxiWriteData  output  32  write data.
dmaAxiWriteValidData  output  1  write data valid.
dmaAxiWriteReadyData  input  1  write data accepted.

Behaviour:
- Clock and reset: one clock (clock); reset is asynchronous and active-low (resetActiveLow).
- Reset values: FSM = IDLE; all outputs 0; address registers, count register and data register cleared to 0.
- Reset mid-transfer: all state and outputs drop immediately to reset values. The transfer is lost and statusDone stays 0.
- FSM states: IDLE, RD_ADDR, RD_DATA, WRITE, DONE.
- IDLE:
  - cfgStart=1 latches source address, destination address, count and both increment flags, and clears statusDone.
  - Next state is RD_ADDR if count != 0. If count == 0, next state is DONE and no bus traffic occurs.
  - cfgStart in any other state is ignored.
- RD_ADDR: dmaAxiReadValid=1 and dmaAxiReadAddress = current source address. When dmaAxiReadReady=1, go to RD_DATA.
- RD_DATA: dmaAxiReadValid stays 1 and dmaAxiReadReadyData=1.
  - Read valid must be held through the data beat because the fabric routes read responses only while the request valid is high.
  - On dmaAxiReadValidData=1, capture dmaAxiReadData into the data register and go to WRITE.
- Read data is never accepted in RD_ADDR: dmaAxiReadReadyData=0 there, even if the slave asserts read ready and read data valid in the same cycle.
- WRITE: dmaAxiWriteValid=1 with the destination address; dmaAxiWriteValidData=1 with the data register.
  - Address and data handshakes complete independently, in either order or in the same cycle, tracked by two done flags.
  - After its handshake, dmaAxiWriteValidData drops. dmaAxiWriteValid stays high until both handshakes are done, because the fabric routes the write data path only while the write address valid is high.
  - When both are done: decrement the count, advance each incrementing address by ADDRESS_STRIDE (modulo 2^32, wrapping silently), and clear both flags.
  - Then go to DONE if the decremented count == 0, else to RD_ADDR.
- DONE: statusDone set to 1 for one cycle, then return to IDLE; statusDone stays high (sticky).
- statusBusy = 1 in RD_ADDR, RD_DATA and WRITE; 0 in IDLE and DONE.
- Throughput: minimum 3 cycles per word with zero-wait slaves.
- Arbitration is owned by the fabric. Stalls appear only as low ready signals, and the engine holds all outputs stable while stalled.
- No alignment checking: the low address bits pass through unchanged.

Decomposition:
- Shared package (bus_pkg): FSM state enum dma_state_t, constant BUS_DATA_WIDTH = 32, and memory-map base constants ROM 0x0000_0000, RAM 0x2000_0000, MMIO 0x4000_0000, for reuse by the interconnect and benches.
- No sub-module: a single FSM plus datapath registers.

Test Plan:
- Basic copy: src=0x2000_0000, dst=0x2000_0100, count=4, both increment, zero-wait RAM model -> reads at 0x..00/04/08/0C; writes to 0x..100/104/108/10C with matching data; statusDone=1 after 12 busy cycles.
- Zero count: start with count=0 -> no read or write valid ever asserted; statusDone=1 two cycles after start; statusBusy never asserted.
- Fixed destination: src=0x2000_0000, dst=0x4000_0000 with cfgDestIncrement=0, count=3 -> all three writes to 0x4000_0000; source reads advance by 4.
- Write handshake ordering: slave asserts write ready first, then write data ready 3 cycles later (and the reverse case, and both in the same cycle) -> exactly one write per word; write valid held until both handshakes complete.
- Read stalls: read ready delayed 5 cycles, read data valid delayed 7 -> read address and read valid stable throughout; write data equals the returned read data.
- Reset and wrap: assert reset in WRITE of word 2 -> all outputs 0 immediately and statusDone=0; then src=0xFFFF_FFFC, count=2 -> second read at 0x0000_0000.
